// File: rtl/seg_pkg.sv
// Shared types for the multiplexed 7-segment driver: glyph type, hex glyph table, scan FSM states.
package seg_pkg;

  typedef logic [6:0] seg7_t;

  // Glyphs are {A,B,C,D,E,F,G}, active-high.
  localparam seg7_t SEG_0 = 7'b1111110;
  localparam seg7_t SEG_1 = 7'b0110000;
  localparam seg7_t SEG_2 = 7'b1101101;
  localparam seg7_t SEG_3 = 7'b1111001;
  localparam seg7_t SEG_4 = 7'b0110011;
  localparam seg7_t SEG_5 = 7'b1011011;
  localparam seg7_t SEG_6 = 7'b1011111;
  localparam seg7_t SEG_7 = 7'b1110000;
  localparam seg7_t SEG_8 = 7'b1111111;
  localparam seg7_t SEG_9 = 7'b1111011;
  localparam seg7_t SEG_A = 7'b1110111;
  localparam seg7_t SEG_B = 7'b0011111;
  localparam seg7_t SEG_C = 7'b1001110;
  localparam seg7_t SEG_D = 7'b0111101;
  localparam seg7_t SEG_E = 7'b1001111;
  localparam seg7_t SEG_F = 7'b1000111;

  typedef enum logic {
    ST_SHOW = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-high 7-segment glyph.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg7_t      seg
);

  // Glyph lookup.
  always_comb begin
    seg = SEG_0;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/segment_led_mux.sv
// Multiplexed N-digit 7-segment driver with frame-synchronous load and anti-ghosting gap.
// Optional macro SEG_LZ_BLANK_EN enables leading-zero suppression.
module segment_led_mux
  import seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int DIV            = 50000,
  parameter int GAP            = 16,
  parameter int EN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*N_DIGITS-1:0] NUM,
  input  logic [N_DIGITS-1:0]   DP,
  input  logic [N_DIGITS-1:0]   BLANK,
  input  logic                  LOAD,
  output logic [N_DIGITS-1:0]   DS_EN,
  output seg7_t                 DS_SEG,
  output logic                  DS_DP,
  output logic                  FRAME_TICK
);

  localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0] DIG_LAST = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] EN_OFF = (EN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam seg7_t SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000;
  localparam logic  DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  state_t                  state_r, state_nxt_s;
  logic [CW-1:0]           cnt_r, cnt_nxt_s;
  logic [IW-1:0]           dig_r, dig_nxt_s;
  logic                    enter_s, wrap_s;
  logic [4*N_DIGITS-1:0]   shadow_num_r, shadow_num_nxt_s, pend_num_r;
  logic [N_DIGITS-1:0]     shadow_dp_r, shadow_dp_nxt_s, pend_dp_r;
  logic [N_DIGITS-1:0]     shadow_blank_r, shadow_blank_nxt_s, pend_blank_r;
  logic                    pend_vld_r;
  logic [3:0]              nib_s;
  seg7_t                   glyph_s, seg_s;
  logic [N_DIGITS-1:0]     lz_mask_s, en_s;
  logic                    dark_s, dp_s;
  logic [N_DIGITS-1:0]     ds_en_r;
  seg7_t                   ds_seg_r;
  logic                    ds_dp_r, frame_tick_r;

  // Scan sequencing: the digit index advances as a SHOW phase ends, so the GAP after reset leads to digit 0.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + 1'b1;
    dig_nxt_s   = dig_r;
    enter_s     = 1'b0;
    case (state_r)
      ST_SHOW: begin
        if (cnt_r == DIV_LAST) begin
          cnt_nxt_s = '0;
          dig_nxt_s = (dig_r == DIG_LAST) ? '0 : dig_r + 1'b1;
          if (GAP == 0) begin
            state_nxt_s = ST_SHOW;
            enter_s     = 1'b1;
          end else begin
            state_nxt_s = ST_GAP;
          end
        end else begin
          state_nxt_s = ST_SHOW;
        end
      end
      ST_GAP: begin
        if ((GAP == 0) || (cnt_r == GAP_LAST)) begin
          cnt_nxt_s   = '0;
          state_nxt_s = ST_SHOW;
          enter_s     = 1'b1;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_GAP;
        cnt_nxt_s   = '0;
        dig_nxt_s   = '0;
      end
    endcase
  end

  assign wrap_s = enter_s && (dig_nxt_s == '0);

  // Pending data replaces the shadow only as digit 0 lights, so one frame never mixes two loads.
  always_comb begin
    if (wrap_s && pend_vld_r) begin
      shadow_num_nxt_s   = pend_num_r;
      shadow_dp_nxt_s    = pend_dp_r;
      shadow_blank_nxt_s = pend_blank_r;
    end else begin
      shadow_num_nxt_s   = shadow_num_r;
      shadow_dp_nxt_s    = shadow_dp_r;
      shadow_blank_nxt_s = shadow_blank_r;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  // Digits above the highest nonzero nibble go dark; digit 0 is never suppressed.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lz_mask_s = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      zero_run     = zero_run & (shadow_num_nxt_s[4*i +: 4] == 4'h0);
      lz_mask_s[i] = zero_run;
    end
  end
`else
  assign lz_mask_s = '0;
`endif

  assign nib_s = shadow_num_nxt_s[{dig_nxt_s, 2'b00} +: 4];

  seg_hex_decoder u_dec (
    .nib (nib_s),
    .seg (glyph_s)
  );

  // Active-high view of what the pins show after the coming edge.
  always_comb begin
    en_s   = '0;
    dark_s = shadow_blank_nxt_s[dig_nxt_s] | lz_mask_s[dig_nxt_s];
    for (int i = 0; i < N_DIGITS; i++) begin
      en_s[i] = (state_nxt_s == ST_SHOW) && (dig_nxt_s == IW'(i));
    end
    if ((state_nxt_s == ST_SHOW) && !dark_s) begin
      seg_s = glyph_s;
      dp_s  = shadow_dp_nxt_s[dig_nxt_s];
    end else begin
      seg_s = 7'b0000000;
      dp_s  = 1'b0;
    end
  end

  // Scan state, shadow and pending registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r        <= ST_GAP;
      cnt_r          <= '0;
      dig_r          <= '0;
      shadow_num_r   <= '0;
      shadow_dp_r    <= '0;
      shadow_blank_r <= '0;
      pend_num_r     <= '0;
      pend_dp_r      <= '0;
      pend_blank_r   <= '0;
      pend_vld_r     <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      dig_r          <= dig_nxt_s;
      shadow_num_r   <= shadow_num_nxt_s;
      shadow_dp_r    <= shadow_dp_nxt_s;
      shadow_blank_r <= shadow_blank_nxt_s;
      if (LOAD) begin
        pend_num_r   <= NUM;
        pend_dp_r    <= DP;
        pend_blank_r <= BLANK;
        pend_vld_r   <= 1'b1;
      end else if (wrap_s) begin
        pend_vld_r   <= 1'b0;
      end else begin
        pend_vld_r   <= pend_vld_r;
      end
    end
  end

  // Pin registers; polarity is applied only here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ds_en_r      <= EN_OFF;
      ds_seg_r     <= SEG_OFF;
      ds_dp_r      <= DP_OFF;
      frame_tick_r <= 1'b0;
    end else begin
      ds_en_r      <= en_s ^ EN_OFF;
      ds_seg_r     <= seg_s ^ SEG_OFF;
      ds_dp_r      <= dp_s ^ DP_OFF;
      frame_tick_r <= wrap_s;
    end
  end

  assign DS_EN      = ds_en_r;
  assign DS_SEG     = ds_seg_r;
  assign DS_DP      = ds_dp_r;
  assign FRAME_TICK = frame_tick_r;

endmodule

// File: tb/tb_segment_led_mux.sv
// Directed bench for segment_led_mux: scan timing, frame-synchronous load, blank/DP, polarity, leading zeros, reset.
module tb_segment_led_mux;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011;
  localparam logic [6:0] G7 = 7'b1110000;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] GF = 7'b1000111;
`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] GZ = 7'b0000000;
`else
  localparam logic [6:0] GZ = 7'b1111110;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] NUM;
  logic [3:0]  DP, BLANK;
  logic        LOAD;
  logic [3:0]  en4, enp;
  logic [2:0]  en3;
  logic [6:0]  seg4, seg3, segp;
  logic        dp4, dp3, dpp, tk4, tk3, tkp;

  int n_vec = 0;
  int n_err = 0;
  int k = 0;

  always #5 CLK = ~CLK;

  segment_led_mux #(.N_DIGITS(4), .DIV(4), .GAP(2), .EN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .NUM(NUM), .DP(DP), .BLANK(BLANK), .LOAD(LOAD),
    .DS_EN(en4), .DS_SEG(seg4), .DS_DP(dp4), .FRAME_TICK(tk4));

  segment_led_mux #(.N_DIGITS(3), .DIV(4), .GAP(2), .EN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .NUM(NUM[11:0]), .DP(DP[2:0]), .BLANK(BLANK[2:0]), .LOAD(LOAD),
    .DS_EN(en3), .DS_SEG(seg3), .DS_DP(dp3), .FRAME_TICK(tk3));

  segment_led_mux #(.N_DIGITS(4), .DIV(4), .GAP(0), .EN_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)) dutp (
    .CLK(CLK), .RST_N(RST_N), .NUM(NUM), .DP(DP), .BLANK(BLANK), .LOAD(LOAD),
    .DS_EN(enp), .DS_SEG(segp), .DS_DP(dpp), .FRAME_TICK(tkp));

  task automatic step_to(input int target);
    while (k < target) begin
      @(negedge CLK);
      k++;
    end
  endtask

  // k counts falling edges after release; k=1 follows the first rising edge out of reset.
  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; LOAD = 1'b0; NUM = 16'h0000; DP = 4'h0; BLANK = 4'h0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    RST_N = 1'b1; LOAD = 1'b0; NUM = 16'hFFFF; DP = 4'hF; BLANK = 4'h0;
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if ({en4, seg4, dp4, tk4} !== {4'b1111, 7'b0000000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset4 got %b exp %b", {en4, seg4, dp4, tk4}, {4'b1111, 7'b0000000, 2'b00});
    end
    n_vec++;
    if ({en3, seg3, dp3, tk3} !== {3'b111, 7'b0000000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset3 got %b exp %b", {en3, seg3, dp3, tk3}, {3'b111, 7'b0000000, 2'b00});
    end
    n_vec++;
    if ({enp, segp, dpp, tkp} !== {4'b0000, 7'b1111111, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL resetp got %b exp %b", {enp, segp, dpp, tkp}, {4'b0000, 7'b1111111, 2'b10});
    end
  endtask

  // Shadow is 0: 2 dark cycles, digit lit 4, dark 2, ...; GAP=0 instance switches digits every 4 cycles.
  task automatic test_scan();
    logic [12:0] e4, ep;
    logic [11:0] e3;
    int d;
    do_reset();
    for (int t = 1; t <= 40; t++) begin
      step_to(t);
      e4 = {4'b1111, 7'b0000000, 2'b00};
      e3 = {3'b111, 7'b0000000, 2'b00};
      if (t >= 2 && ((t - 2) % 6) < 4) begin
        d  = ((t - 2) / 6) % 4;
        e4 = {~(4'b0001 << d), (d == 0) ? G0 : GZ, 1'b0, ((t - 2) % 24) == 0};
        d  = ((t - 2) / 6) % 3;
        e3 = {~(3'b001 << d), (d == 0) ? G0 : GZ, 1'b0, ((t - 2) % 18) == 0};
      end
      d  = ((t - 1) / 4) % 4;
      ep = {4'b0001 << d, ~((d == 0) ? G0 : GZ), 1'b1, ((t - 1) % 16) == 0};
      n_vec++;
      if ({en4, seg4, dp4, tk4} !== e4) begin
        n_err++; $display("FAIL scan4 t=%0d got %b exp %b", t, {en4, seg4, dp4, tk4}, e4);
      end
      n_vec++;
      if ({en3, seg3, dp3, tk3} !== e3) begin
        n_err++; $display("FAIL scan3 t=%0d got %b exp %b", t, {en3, seg3, dp3, tk3}, e3);
      end
      n_vec++;
      if ({enp, segp, dpp, tkp} !== ep) begin
        n_err++; $display("FAIL scanp t=%0d got %b exp %b", t, {enp, segp, dpp, tkp}, ep);
      end
    end
  endtask

  // Loads at t=5 and t=9 (last wins) show from the t=26 frame; load on the wrap edge waits one more frame.
  task automatic test_load();
    logic [12:0] e;
    bit chk;
    do_reset();
    for (int t = 1; t <= 68; t++) begin
      step_to(t);
      chk = 1'b1;
      case (t)
        8:       e = {4'b1101, GZ, 2'b00};
        14:      e = {4'b1011, GZ, 2'b00};
        25:      e = {4'b1111, 7'b0000000, 2'b00};
        26:      e = {4'b1110, GF, 2'b01};
        27:      e = {4'b1110, GF, 2'b00};
        32:      e = {4'b1101, GA, 2'b00};
        38:      e = {4'b1011, G2, 2'b00};
        44:      e = {4'b0111, G1, 2'b00};
        50:      e = {4'b1110, G4, 2'b01};
        68:      e = {4'b0111, G3, 2'b00};
        default: begin chk = 1'b0; e = 13'd0; end
      endcase
      if (chk) begin
        n_vec++;
        if ({en4, seg4, dp4, tk4} !== e) begin
          n_err++; $display("FAIL load t=%0d got %b exp %b", t, {en4, seg4, dp4, tk4}, e);
        end
      end
      LOAD = (t == 5) || (t == 9) || (t == 25);
      NUM  = (t == 5) ? 16'h9999 : (t == 9) ? 16'h12AF : (t == 25) ? 16'h3344 : 16'hDEAD;
    end
    LOAD = 1'b0;
  endtask

  task automatic test_blank_dp();
    logic [12:0] e, ep;
    bit chk, chkp;
    do_reset();
    for (int t = 1; t <= 44; t++) begin
      step_to(t);
      chk = 1'b1;
      case (t)
        2:       e = {4'b1110, G0, 2'b01};
        26:      e = {4'b1110, G8, 2'b11};
        32:      e = {4'b1101, G8, 2'b00};
        38:      e = {4'b1011, 7'b0000000, 2'b00};
        44:      e = {4'b0111, G8, 2'b00};
        default: begin chk = 1'b0; e = 13'd0; end
      endcase
      chkp = 1'b1;
      case (t)
        17:      ep = {4'b0001, 7'b0000000, 2'b01};
        21:      ep = {4'b0010, 7'b0000000, 2'b10};
        25:      ep = {4'b0100, 7'b1111111, 2'b10};
        default: begin chkp = 1'b0; ep = 13'd0; end
      endcase
      if (chk) begin
        n_vec++;
        if ({en4, seg4, dp4, tk4} !== e) begin
          n_err++; $display("FAIL blank t=%0d got %b exp %b", t, {en4, seg4, dp4, tk4}, e);
        end
      end
      if (chkp) begin
        n_vec++;
        if ({enp, segp, dpp, tkp} !== ep) begin
          n_err++; $display("FAIL polarity t=%0d got %b exp %b", t, {enp, segp, dpp, tkp}, ep);
        end
      end
      LOAD  = (t == 1);
      NUM   = (t == 1) ? 16'h8888 : 16'h0000;
      DP    = (t == 1) ? 4'b0001 : 4'b0000;
      BLANK = (t == 1) ? 4'b0100 : 4'b0000;
    end
    LOAD = 1'b0; DP = 4'h0; BLANK = 4'h0;
  endtask

  task automatic test_lz();
    logic [12:0] e;
    bit chk;
    do_reset();
    for (int t = 1; t <= 56; t++) begin
      step_to(t);
      chk = 1'b1;
      case (t)
        26:      e = {4'b1110, G0, 2'b01};
        32:      e = {4'b1101, G3, 2'b00};
        38:      e = {4'b1011, GZ, 2'b00};
        44:      e = {4'b0111, GZ, 2'b00};
        50:      e = {4'b1110, G0, 2'b01};
        56:      e = {4'b1101, GZ, 2'b00};
        default: begin chk = 1'b0; e = 13'd0; end
      endcase
      if (chk) begin
        n_vec++;
        if ({en4, seg4, dp4, tk4} !== e) begin
          n_err++; $display("FAIL lzero t=%0d got %b exp %b", t, {en4, seg4, dp4, tk4}, e);
        end
      end
      LOAD = (t == 1) || (t == 45);
      NUM  = (t == 1) ? 16'h0030 : 16'h0000;
    end
    LOAD = 1'b0;
  endtask

  // Reset asserted mid-cycle while digit 2 shows 7 with a further load pending.
  task automatic test_reset_mid();
    logic [12:0] e;
    bit chk;
    do_reset();
    for (int t = 1; t <= 39; t++) begin
      step_to(t);
      if (t == 38) begin
        n_vec++;
        if ({en4, seg4, dp4, tk4} !== {4'b1011, G7, 2'b00}) begin
          n_err++; $display("FAIL midpre got %b exp %b", {en4, seg4, dp4, tk4}, {4'b1011, G7, 2'b00});
        end
      end
      LOAD = (t == 1) || (t == 30);
      NUM  = (t == 1) ? 16'h7777 : 16'h5555;
    end
    LOAD = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    n_vec++;
    if ({en4, seg4, dp4, tk4} !== {4'b1111, 7'b0000000, 2'b00}) begin
      n_err++; $display("FAIL midasync got %b exp %b", {en4, seg4, dp4, tk4}, {4'b1111, 7'b0000000, 2'b00});
    end
    n_vec++;
    if ({enp, segp, dpp, tkp} !== {4'b0000, 7'b1111111, 2'b10}) begin
      n_err++; $display("FAIL midasyncp got %b exp %b", {enp, segp, dpp, tkp}, {4'b0000, 7'b1111111, 2'b10});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    k = 0;
    for (int t = 1; t <= 26; t++) begin
      step_to(t);
      chk = 1'b1;
      case (t)
        1:       e = {4'b1111, 7'b0000000, 2'b00};
        2:       e = {4'b1110, G0, 2'b01};
        14:      e = {4'b1011, GZ, 2'b00};
        26:      e = {4'b1110, G0, 2'b01};
        default: begin chk = 1'b0; e = 13'd0; end
      endcase
      if (chk) begin
        n_vec++;
        if ({en4, seg4, dp4, tk4} !== e) begin
          n_err++; $display("FAIL midpost t=%0d got %b exp %b", t, {en4, seg4, dp4, tk4}, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_blank_dp();
    test_lz();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
